// File: rtl/pacman_move_ctrl.sv
// Pac-Man movement sequencer: turn probe, forward probe, one step per frame.
// Optional wall_ack timeout watchdog: define MOVE_WALL_TIMEOUT_EN.
module pacman_move_ctrl #(
  parameter int unsigned STEP    = 1,
  parameter int unsigned SIZE    = 4,
  parameter int unsigned X_MIN   = 26,
  parameter int unsigned X_MAX   = 598,
  parameter int unsigned Y_MIN   = 26,
  parameter int unsigned Y_MAX   = 454,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_tick,
  input  logic [7:0] keycode,
  input  logic [9:0] pos_x,
  input  logic [9:0] pos_y,
  output logic       wall_req,
  output logic [9:0] wall_x,
  output logic [9:0] wall_y,
  input  logic       wall_ack,
  input  logic       wall_hit,
  output logic       move_en,
  output logic [9:0] motion_x,
  output logic [9:0] motion_y,
  output logic [1:0] cur_dir,
  output logic       moving,
  output logic       busy,
  output logic       frame_miss,
  output logic       lookup_err
);

  localparam logic [10:0] OFF = 11'(SIZE + STEP);
  localparam logic [10:0] XLO = 11'(X_MIN);
  localparam logic [10:0] XHI = 11'(X_MAX);
  localparam logic [10:0] YLO = 11'(Y_MIN);
  localparam logic [10:0] YHI = 11'(Y_MAX);
  localparam logic [9:0]  STP = 10'(STEP);
  localparam logic [9:0]  STN = ~STP + 10'd1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    TURN   = 2'd1,
    FWD    = 2'd2,
    COMMIT = 2'd3
  } state_t;

  state_t      state, state_nx;
  logic        key_v, pend_v;
  logic [1:0]  key_dir, pend_dir;
  logic [1:0]  turn_dir, probe_dir;
  logic [10:0] px, py;
  logic        low_ok, in_b;
  logic        probing, ack, clear;
  logic        blocked, tmo;

  function automatic logic [19:0] step_of(
    input logic [1:0] d
  );
    logic [19:0] r;
    unique case (d)
      2'd0:    r = {STN, 10'd0};
      2'd1:    r = {STP, 10'd0};
      2'd2:    r = {10'd0, STP};
      default: r = {10'd0, STN};
    endcase
    return r;
  endfunction

  always_comb begin
    key_v   = 1'b1;
    key_dir = 2'd0;
    unique case (1'b1)
      (keycode == 8'h04): key_dir = 2'd0;
      (keycode == 8'h07): key_dir = 2'd1;
      (keycode == 8'h16): key_dir = 2'd2;
      (keycode == 8'h1A): key_dir = 2'd3;
      default:            key_v   = 1'b0;
    endcase
  end

  // Subtractions are guarded so an underflow reads as blocked.
  always_comb begin
    probe_dir = (state == TURN) ? turn_dir : cur_dir;
    px     = {1'b0, pos_x};
    py     = {1'b0, pos_y};
    low_ok = 1'b1;
    unique case (probe_dir)
      2'd0: begin
        low_ok = ({1'b0, pos_x} >= OFF);
        px     = {1'b0, pos_x} - OFF;
      end
      2'd1: px = {1'b0, pos_x} + OFF;
      2'd2: py = {1'b0, pos_y} + OFF;
      default: begin
        low_ok = ({1'b0, pos_y} >= OFF);
        py     = {1'b0, pos_y} - OFF;
      end
    endcase
    in_b = low_ok
        && px >= XLO && px <= XHI
        && py >= YLO && py <= YHI;
  end

  assign probing = (state == TURN)
                || (state == FWD);
  assign ack     = wall_req & wall_ack;
  assign clear   = ack & ~wall_hit;
  assign blocked = probing
                 & (~in_b | tmo | (ack & wall_hit));

`ifdef MOVE_WALL_TIMEOUT_EN
  logic [7:0] cnt;
  assign tmo = wall_req & ~wall_ack
             & (cnt == 8'(TIMEOUT - 1));
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      cnt        <= '0;
      lookup_err <= 1'b0;
    end else begin
      if (!wall_req || wall_ack || tmo) cnt <= '0;
      else                              cnt <= cnt + 8'd1;
      if (tmo) lookup_err <= 1'b1;
    end
  end
`else
  assign tmo        = 1'b0;
  assign lookup_err = 1'b0;
`endif

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:
        if (frame_tick)
          state_nx = (pend_v || key_v) ? TURN : FWD;
      TURN:
        if (!in_b || tmo)   state_nx = FWD;
        else if (ack)       state_nx = wall_hit ? FWD : COMMIT;
      FWD:
        if (!in_b || tmo || ack) state_nx = COMMIT;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy     = (state != IDLE);
    move_en  = (state == COMMIT);
    wall_req = probing & in_b;
    wall_x   = wall_req ? px[9:0] : 10'd0;
    wall_y   = wall_req ? py[9:0] : 10'd0;
  end

  // A key arriving with the tick steers that same frame's turn probe.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      pend_v     <= 1'b0;
      pend_dir   <= 2'd0;
      turn_dir   <= 2'd0;
      cur_dir    <= 2'd0;
      motion_x   <= 10'd0;
      motion_y   <= 10'd0;
      moving     <= 1'b0;
      frame_miss <= 1'b0;
    end else begin
      if (key_v) begin
        pend_dir <= key_dir;
        pend_v   <= 1'b1;
      end else if (state == TURN && clear) begin
        pend_v   <= 1'b0;
      end
      if (state == IDLE && frame_tick)
        turn_dir <= key_v ? key_dir : pend_dir;
      if (frame_tick && state != IDLE)
        frame_miss <= 1'b1;
      if (clear) begin
        {motion_x, motion_y} <= step_of(probe_dir);
        moving <= 1'b1;
        if (state == TURN) cur_dir <= turn_dir;
      end else if (state == FWD && blocked) begin
        motion_x <= 10'd0;
        motion_y <= 10'd0;
        moving   <= 1'b0;
      end
    end
  end

endmodule
